pipe_skid_stage: RTL and testbench

Elastic two-entry pipeline stage that sits between adjacent pipeline stages of the OoO core (e.g. decode → rename). It carries a BITLENGTH-bit payload with a valid/ready handshake on both sides and drives the enables of its two internal RegEnXBit data registers (main, skid) from a small state machine. Its purpose is to remove the combinational `out_ready → in_ready` path, while sustaining one transfer per cycle and supporting a pipeline flush.

---
 rtl/pipe_skid_stage.sv | 136 +++++++++++++
 tb/tb_pipe_skid_stage.sv | 133 +++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// Elastic two-entry pipeline stage: main/skid payload registers steered by a
// small FSM so that in_ready is registered and never combinational on out_ready.

module RegEnXBit #(
    parameter int unsigned BITLENGTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [BITLENGTH-1:0] d,
    output logic [BITLENGTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

module pipe_skid_stage #(
    parameter int unsigned BITLENGTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [BITLENGTH-1:0] in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [BITLENGTH-1:0] out_data,
    input  logic                 out_ready,
    output logic [1:0]           occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic                 out_valid_q, out_valid_d;
    logic                 in_ready_q, in_ready_d;
    logic [1:0]           occupancy_q, occupancy_d;
    logic                 main_en, skid_en, main_from_skid;
    logic [BITLENGTH-1:0] main_d, main_q, skid_q;

    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_valid) begin
                        state_d = FULL;
                        main_en = 1'b1;
                    end
                end
                FULL: begin
                    if (in_valid && out_ready) begin
                        main_en = 1'b1;
                    end else if (in_valid) begin
                        state_d = SKID;
                        skid_en = 1'b1;
                    end else if (out_ready) begin
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    if (out_ready) begin
                        state_d        = FULL;
                        main_en        = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Status outputs are decoded from the next state so they leave flops directly.
    always_comb begin
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != SKID);
        case (state_d)
            FULL:    occupancy_d = 2'd1;
            SKID:    occupancy_d = 2'd2;
            default: occupancy_d = 2'd0;
        endcase
        main_d = main_from_skid ? skid_q : in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            occupancy_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            occupancy_q <= occupancy_d;
        end
    end

    RegEnXBit #(.BITLENGTH(BITLENGTH)) u_main (
        .clk   (clk),
        .reset (reset),
        .en    (main_en),
        .d     (main_d),
        .q     (main_q)
    );

    RegEnXBit #(.BITLENGTH(BITLENGTH)) u_skid (
        .clk   (clk),
        .reset (reset),
        .en    (skid_en),
        .d     (in_data),
        .q     (skid_q)
    );

    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign occupancy = occupancy_q;
    assign out_data  = main_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Randomized bench for pipe_skid_stage against a FIFO-queue reference model.

module tb_pipe_skid_stage;

    localparam int unsigned W = 64;

    logic         clk = 1'b0;
    logic         reset, flush, in_valid, out_ready;
    logic         in_ready, out_valid;
    logic [W-1:0] in_data, out_data;
    logic [1:0]   occupancy;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] mq[$];
    bit           main_clean = 1'b0;
    bit           started = 1'b0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.BITLENGTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Queue semantics: deliver pops the head, accept pushes when fewer than two held.
    task automatic model_edge();
        bit pop, push;
        if (reset) begin
            mq.delete();
            main_clean = 1'b1;
        end else if (flush) begin
            mq.delete();
        end else begin
            pop  = (mq.size() > 0) && out_ready;
            push = in_valid && (mq.size() < 2);
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back(in_data);
                main_clean = 1'b0;
            end
        end
    endtask

    task automatic check_status(input string ph);
        check({ph, "_occupancy"}, W'(occupancy), W'(mq.size()));
        check({ph, "_out_valid"}, W'(out_valid), W'(mq.size() != 0));
        check({ph, "_in_ready"}, W'(in_ready), W'(mq.size() != 2));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        started = 1'b1;
        check_status("post");
        if (mq.size() > 0) check("out_data", out_data, mq[0]);
        else if (main_clean) check("out_data_rst", out_data, '0);
    endtask

    // Drive new inputs mid-cycle, then confirm status outputs did not react.
    task automatic drive(input logic r, input logic f, input logic iv,
                         input logic [W-1:0] d, input logic ordy);
        reset = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        #3;
        if (started) check_status("comb");
    endtask

    initial begin
        // reset with an offered payload that must not be captured
        drive(1, 0, 1, 64'hAA, 0); step();
        drive(1, 0, 1, 64'hAA, 0); step();
        drive(0, 0, 0, '0, 0); step();
        check("rst_idle_data", out_data, '0);
        check("rst_idle_valid", W'(out_valid), '0);

        // streaming
        drive(0, 0, 1, 64'h1, 1); step(); check("stream1", out_data, 64'h1);
        drive(0, 0, 1, 64'h2, 1); step(); check("stream2", out_data, 64'h2);
        drive(0, 0, 1, 64'h3, 1); step(); check("stream3", out_data, 64'h3);
        check("stream_occ", W'(occupancy), 64'd1);
        drive(0, 0, 0, '0, 1); step();

        // backpressure
        drive(0, 0, 1, 64'h10, 0); step();
        drive(0, 0, 1, 64'h20, 0); step();
        check("bp_occ", W'(occupancy), 64'd2);
        check("bp_in_ready", W'(in_ready), '0);
        drive(0, 0, 1, 64'h30, 0); step();
        check("bp_head", out_data, 64'h10);
        drive(0, 0, 0, '0, 1); step();
        check("bp_second", out_data, 64'h20);
        check("bp_in_ready_back", W'(in_ready), 64'd1);
        drive(0, 0, 0, '0, 1); step();
        check("bp_drained", W'(occupancy), '0);

        // flush while holding two entries
        drive(0, 0, 1, 64'h5, 0); step();
        drive(0, 0, 1, 64'h6, 0); step();
        drive(0, 1, 1, 64'h7, 0); step();
        check("flush_occ", W'(occupancy), '0);
        check("flush_valid", W'(out_valid), '0);
        drive(0, 0, 0, '0, 1); step();
        check("flush_no7", W'(out_valid), '0);

        // random soak
        for (int i = 0; i < 10000; i++) begin
            drive(($urandom_range(999) == 0), ($urandom_range(99) < 2),
                  1'($urandom_range(1)), {$urandom, $urandom}, 1'($urandom_range(1)));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
